// File: rtl/reset_seq_pkg.sv
// Shared constants for the reset sequencer: FSM state encoding and counter sizing.
package reset_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_ASSERT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_HOLD    = 2'd1;
    localparam logic [STATE_W-1:0] ST_RELEASE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE    = 2'd3;

    // Down-counter must hold the larger of the two reload values plus one.
    function automatic int cnt_width(input int hold_cycles, input int step_cycles);
        int largest;
        largest = (hold_cycles > step_cycles) ? hold_cycles : step_cycles;
        return $clog2(largest + 1);
    endfunction

endpackage

// File: rtl/sync_bit_array.sv
// WIDTH parallel bits, each through a STAGES-deep flop chain; synchronous reset loads RST_VAL.
module sync_bit_array #(
    parameter int   WIDTH   = 1,
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= {WIDTH{RST_VAL}};
            end
        end else begin
            stage_q[0] <= data;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign synced = stage_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Collects async and software reset requests, holds all downstream domains in reset,
// then releases them one by one in index order with fixed spacing.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_n_i,
    input  logic               sw_rst_i,
    output logic [NUM_OUT-1:0] rst_n_o,
    output logic               done_o,
    output logic [NUM_REQ:0]   cause_o
);

    if (NUM_REQ < 1 || SYNC_STAGES < 2 || NUM_OUT < 1 ||
        HOLD_CYCLES < 1 || STEP_CYCLES < 1) begin : g_bad_params
        $error("reset_sequencer: illegal parameter values");
    end

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
    localparam int IDX_W = $clog2(NUM_OUT + 1);

    // The edge that leaves ASSERT already counts as the first hold cycle.
    localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'((HOLD_CYCLES > 1) ? HOLD_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0]   STEP_LOAD  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_OUT - 1);
    localparam logic [STATE_W-1:0] FIRST_NEXT = (NUM_OUT == 1) ? ST_DONE : ST_RELEASE;

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [NUM_OUT-1:0] rst_n_q;
    logic               done_q;
    logic [NUM_REQ:0]   cause_q;

    logic [NUM_REQ-1:0] req_n_sync;
    logic [NUM_REQ:0]   active_vec;
    logic               any_active;
    logic               first_release;

    sync_bit_array #(
        .WIDTH   (NUM_REQ),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_req_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data   (req_n_i),
        .synced (req_n_sync)
    );

    assign active_vec    = {sw_rst_i, ~req_n_sync};
    assign any_active    = |active_vec;
    assign first_release = !any_active &&
                           ((state == ST_ASSERT && HOLD_CYCLES == 1) ||
                            (state == ST_HOLD && cnt == '0));

    // A live request always wins over counter expiry; cause only latches on entry to ASSERT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_ASSERT;
            cnt     <= '0;
            idx     <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            cause_q <= '0;
        end else if (any_active) begin
            if (state != ST_ASSERT) begin
                cause_q <= active_vec;
            end
            state   <= ST_ASSERT;
            rst_n_q <= '0;
            done_q  <= 1'b0;
        end else if (first_release) begin
            state   <= FIRST_NEXT;
            rst_n_q <= NUM_OUT'(1);
            done_q  <= (NUM_OUT == 1);
            idx     <= IDX_W'(1);
            cnt     <= STEP_LOAD;
        end else begin
            case (state)
                ST_ASSERT: begin
                    state <= ST_HOLD;
                    cnt   <= HOLD_LOAD;
                end
                ST_HOLD: begin
                    cnt <= cnt - 1'b1;
                end
                ST_RELEASE: begin
                    if (cnt == '0) begin
                        rst_n_q <= rst_n_q | (NUM_OUT'(1) << idx);
                        if (idx == LAST_IDX) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                            cnt <= STEP_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rst_n_o = rst_n_q;
    assign done_o  = done_q;
    assign cause_o = cause_q;

endmodule
